// File: rtl/mem_fill_engine.sv
// rtl/mem_fill_engine.sv - contiguous-range RAM initialiser with selectable data pattern
module mem_fill_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] step,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              mem_ready,
  input  logic              abort,
  output logic              wen,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              finished
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] step_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  k_q;
  logic              accept;
  logic              last;
  logic [DATA_W-1:0] first_data;
  logic [DATA_W-1:0] next_data;

  // Abort suppresses the write of its own cycle, so it also blocks acceptance.
  assign accept = (state_q == S_WRITE) && mem_ready && !abort;
  assign last   = (k_q == len_q - LEN_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection; start is only looked at in IDLE, abort only in WRITE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (length != '0) ? S_WRITE : S_FINISH;
      S_WRITE:  if (abort || (accept && last)) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    wen      = (state_q == S_WRITE) && !abort;
    busy     = (state_q == S_WRITE);
    finished = (state_q == S_FINISH);
  end

  // Data for write 0, taken from the live inputs at the start cycle.
  always_comb begin
    first_data = '0;
    case (mode)
      2'd0:    first_data = DATA_W'(base_addr);
      2'd2:    first_data = DATA_W'(length - LEN_W'(1));
      default: first_data = fill_value;
    endcase
  end

  // Data for write k+1 derived incrementally from write k (ramp is a running add).
  always_comb begin
    next_data = data;
    case (mode_q)
      2'd0:    next_data = DATA_W'(address + ADDR_W'(1));
      2'd1:    next_data = data;
      2'd2:    next_data = data - DATA_W'(1);
      default: next_data = data + step_q;
    endcase
  end

  // Run parameters are latched at start; address/data only move on an accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= '0;
      step_q  <= '0;
      len_q   <= '0;
      k_q     <= '0;
      address <= '0;
      data    <= '0;
    end else if (state_q == S_IDLE && start) begin
      mode_q  <= mode;
      step_q  <= step;
      len_q   <= length;
      k_q     <= '0;
      address <= base_addr;
      data    <= first_data;
    end else if (accept && !last) begin
      k_q     <= k_q + LEN_W'(1);
      address <= address + ADDR_W'(1);
      data    <= next_data;
    end
  end

endmodule
